// File: rtl/lzw_forward_prepare_mc.sv
// Splits GMII frames into header/payload FWFT FIFOs with frame-level admission control.
// Optional: define LZW_FWD_DROP_CNT_EN to add the saturating O_drop_cnt output.

module lzw_forward_prepare_mc_fifo #(
  parameter int W  = 9,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic [AW:0]  free
);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(2**AW);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  always_comb begin
    empty    = (count_q == '0);
    free     = DEPTH - count_q;
    do_wr    = wr && (count_q != DEPTH);
    do_rd    = rd && !empty;
    rdata    = empty ? '0 : mem[rd_ptr_q];
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module lzw_forward_prepare_mc #(
  parameter int DW        = 8,
  parameter int HEAD_LEN  = 14,
  parameter int HEAD_AW   = 6,
  parameter int PLOAD_AW  = 11,
  parameter int MAX_PLOAD = 1504,
  parameter int FINFO_AW  = 4
) (
  input  logic          I_sys_clk,
  input  logic          I_sys_rst,
  input  logic [DW-1:0] I_gmii_txd,
  input  logic          I_gmii_txen,
  output logic          O_head_no_pload,
  output logic          O_fifo_head_req,
  input  logic          I_fifo_head_ack,
  input  logic          I_fifo_head_rd,
  output logic [DW:0]   O_fifo_head_rdata,
  output logic          O_fifo_head_full,
  output logic          O_fifo_head_empty,
  output logic          O_fifo_pload_req,
  input  logic          I_fifo_pload_ack,
  input  logic          I_fifo_pload_rd,
  output logic [DW:0]   O_fifo_pload_rdata,
  output logic          O_fifo_pload_empty,
  output logic          O_fifo_pload_full,
  output logic [DW-1:0] O_pload_txd,
  output logic          O_pload_txen
`ifdef LZW_FWD_DROP_CNT_EN
  ,
  output logic [15:0]   O_drop_cnt
`endif
);
  localparam int PCNT_W = PLOAD_AW + 1;
  localparam logic [HEAD_AW:0]  HEAD_NEED  = (HEAD_AW+1)'(HEAD_LEN);
  localparam logic [PLOAD_AW:0] PLOAD_NEED = (PLOAD_AW+1)'(MAX_PLOAD);
  localparam logic [7:0]        HEAD_LAST  = 8'(HEAD_LEN - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PLOAD, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     in_txd_q, wr_txd_q;
  logic              in_txen_q, wr_txen_q, sync_q;
  logic              sync_d;
  logic [7:0]        idx_q, idx_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  logic              sof, w_eof, last_head, admit;
  logic              head_wr, pload_wr, finfo_wr, pcnt_inc, pcnt_dec;
  logic [DW:0]       head_wdata, pload_wdata;
  logic [0:0]        finfo_wdata, finfo_rdata;
  logic              head_empty, pload_empty, finfo_empty;
  logic [HEAD_AW:0]  head_free;
  logic [PLOAD_AW:0] pload_free;
  logic [FINFO_AW:0] finfo_free;

  // sync_q blocks a false SOF when reset releases in the middle of a frame.
  assign sof       = in_txen_q & ~wr_txen_q & sync_q;
  assign w_eof     = wr_txen_q & ~in_txen_q;
  assign last_head = (idx_q == HEAD_LAST);
  assign admit     = (head_free >= HEAD_NEED) && (pload_free >= PLOAD_NEED) && (finfo_free != '0);
  assign sync_d    = sync_q | ~I_gmii_txen;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    head_wr     = 1'b0;
    head_wdata  = {1'b0, wr_txd_q};
    pload_wr    = 1'b0;
    pload_wdata = {w_eof, wr_txd_q};
    finfo_wr    = 1'b0;
    finfo_wdata = 1'b0;
    pcnt_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sof) begin
          idx_d   = '0;
          state_d = admit ? S_HEAD : S_DROP;
        end
      end
      S_HEAD: begin
        if (wr_txen_q) begin
          head_wr    = 1'b1;
          head_wdata = {w_eof | last_head, wr_txd_q};
          idx_d      = idx_q + 8'd1;
          if (w_eof) begin
            state_d     = S_IDLE;
            finfo_wr    = 1'b1;
            finfo_wdata = 1'b1;
          end else if (last_head) begin
            state_d = S_PLOAD;
          end
        end
      end
      S_PLOAD: begin
        if (wr_txen_q) begin
          pload_wr = 1'b1;
          if (w_eof) begin
            state_d  = S_IDLE;
            finfo_wr = 1'b1;
            pcnt_inc = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (w_eof) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcnt_dec = I_fifo_pload_ack && (pcnt_q != '0);
    pcnt_d   = pcnt_q;
    if (pcnt_inc && !pcnt_dec) begin
      pcnt_d = pcnt_q + PCNT_ONE;
    end else if (!pcnt_inc && pcnt_dec) begin
      pcnt_d = pcnt_q - PCNT_ONE;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst) begin
      state_q   <= S_IDLE;
      in_txd_q  <= '0;
      in_txen_q <= 1'b0;
      wr_txd_q  <= '0;
      wr_txen_q <= 1'b0;
      sync_q    <= ~I_gmii_txen;
      idx_q     <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_txd_q  <= I_gmii_txd;
      in_txen_q <= I_gmii_txen;
      wr_txd_q  <= in_txd_q;
      wr_txen_q <= in_txen_q;
      sync_q    <= sync_d;
      idx_q     <= idx_d;
      pcnt_q    <= pcnt_d;
    end
  end

  lzw_forward_prepare_mc_fifo #(.W(DW+1), .AW(HEAD_AW)) u_head_fifo (
    .clk   (I_sys_clk),
    .rst_n (I_sys_rst),
    .wr    (head_wr),
    .wdata (head_wdata),
    .rd    (I_fifo_head_rd),
    .rdata (O_fifo_head_rdata),
    .empty (head_empty),
    .free  (head_free)
  );

  lzw_forward_prepare_mc_fifo #(.W(DW+1), .AW(PLOAD_AW)) u_pload_fifo (
    .clk   (I_sys_clk),
    .rst_n (I_sys_rst),
    .wr    (pload_wr),
    .wdata (pload_wdata),
    .rd    (I_fifo_pload_rd),
    .rdata (O_fifo_pload_rdata),
    .empty (pload_empty),
    .free  (pload_free)
  );

  // One entry per admitted frame; the entry is the frame's no-payload flag.
  lzw_forward_prepare_mc_fifo #(.W(1), .AW(FINFO_AW)) u_finfo_fifo (
    .clk   (I_sys_clk),
    .rst_n (I_sys_rst),
    .wr    (finfo_wr),
    .wdata (finfo_wdata),
    .rd    (I_fifo_head_ack),
    .rdata (finfo_rdata),
    .empty (finfo_empty),
    .free  (finfo_free)
  );

  assign O_head_no_pload    = finfo_rdata[0];
  assign O_fifo_head_req    = ~finfo_empty;
  assign O_fifo_head_empty  = head_empty;
  assign O_fifo_head_full   = (head_free == '0);
  assign O_fifo_pload_empty = pload_empty;
  assign O_fifo_pload_full  = (pload_free == '0);
  assign O_fifo_pload_req   = (pcnt_q != '0);
  assign O_pload_txen       = pload_wr;
  assign O_pload_txd        = pload_wr ? wr_txd_q : '0;

`ifdef LZW_FWD_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  assign drop = (state_q == S_IDLE) & sof & ~admit;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign O_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_lzw_forward_prepare_mc.sv
// Scoreboard bench for lzw_forward_prepare_mc; LZW_FWD_DROP_CNT_EN enables drop-counter checks.
`timescale 1ns/1ps
module tb_lzw_forward_prepare_mc;
  localparam int HEAD_LEN = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] txd;
  logic       txen;
  logic       head_ack, head_rd, pload_ack, pload_rd;
  logic       o_no_pload, o_head_req, o_head_full, o_head_empty;
  logic       o_pload_req, o_pload_empty, o_pload_full, o_pload_txen;
  logic [8:0] o_head_rdata, o_pload_rdata;
  logic [7:0] o_pload_txd;
`ifdef LZW_FWD_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_head[$];
  logic [8:0] exp_pload[$];
  logic       exp_nopl[$];
  logic [7:0] exp_pt[$];

  always #2 clk = ~clk;

  lzw_forward_prepare_mc dut (
    .I_sys_clk          (clk),
    .I_sys_rst          (rst_n),
    .I_gmii_txd         (txd),
    .I_gmii_txen        (txen),
    .O_head_no_pload    (o_no_pload),
    .O_fifo_head_req    (o_head_req),
    .I_fifo_head_ack    (head_ack),
    .I_fifo_head_rd     (head_rd),
    .O_fifo_head_rdata  (o_head_rdata),
    .O_fifo_head_full   (o_head_full),
    .O_fifo_head_empty  (o_head_empty),
    .O_fifo_pload_req   (o_pload_req),
    .I_fifo_pload_ack   (pload_ack),
    .I_fifo_pload_rd    (pload_rd),
    .O_fifo_pload_rdata (o_pload_rdata),
    .O_fifo_pload_empty (o_pload_empty),
    .O_fifo_pload_full  (o_pload_full),
    .O_pload_txd        (o_pload_txd),
    .O_pload_txen       (o_pload_txen)
`ifdef LZW_FWD_DROP_CNT_EN
    ,
    .O_drop_cnt         (o_drop_cnt)
`endif
  );

  // Pass-through monitor: every asserted O_pload_txen must match the next expected payload byte.
  always @(negedge clk) begin
    if (o_pload_txen === 1'b1) begin
      checks++;
      if (exp_pt.size() == 0) begin
        failures++;
        $display("FAIL passthrough_unexpected got=%h exp=none", o_pload_txd);
      end else begin
        logic [7:0] e;
        e = exp_pt.pop_front();
        if (o_pload_txd !== e) begin
          failures++;
          $display("FAIL passthrough_data got=%h exp=%h", o_pload_txd, e);
        end else begin
          $display("pt byte %h ok", o_pload_txd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input int start, input bit admit);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      tick();
      b    = 8'(start + i);
      txen = 1'b1;
      txd  = b;
      if (admit) begin
        if (i < HEAD_LEN) exp_head.push_back({(i == len-1) || (i == HEAD_LEN-1), b});
        else begin
          exp_pload.push_back({i == len-1, b});
          exp_pt.push_back(b);
        end
      end
    end
    if (admit) exp_nopl.push_back(len <= HEAD_LEN);
    tick();
    txen = 1'b0;
    txd  = '0;
    $display("frame len=%0d start=%h admit=%0b sent", len, start[7:0], admit);
  endtask

  task automatic read_head_frame();
    logic [8:0] w;
    int n;
    w = '0;
    while (!w[8]) begin
      n = 0;
      while (o_head_empty === 1'b1 && n < 50) begin tick(); n++; end
      if (exp_head.size() == 0) begin
        checks++; failures++;
        $display("FAIL head_scoreboard_underrun got=%h exp=none", o_head_rdata);
        break;
      end
      w = exp_head.pop_front();
      checks++;
      if (o_head_rdata !== w) begin
        failures++;
        $display("FAIL head_word got=%h exp=%h", o_head_rdata, w);
      end
      head_rd = 1'b1; tick(); head_rd = 1'b0;
    end
  endtask

  task automatic read_pload_frame();
    logic [8:0] w;
    int n;
    w = '0;
    while (!w[8]) begin
      n = 0;
      while (o_pload_empty === 1'b1 && n < 50) begin tick(); n++; end
      if (exp_pload.size() == 0) begin
        checks++; failures++;
        $display("FAIL pload_scoreboard_underrun got=%h exp=none", o_pload_rdata);
        break;
      end
      w = exp_pload.pop_front();
      checks++;
      if (o_pload_rdata !== w) begin
        failures++;
        $display("FAIL pload_word got=%h exp=%h", o_pload_rdata, w);
      end
      pload_rd = 1'b1; tick(); pload_rd = 1'b0;
    end
  endtask

  task automatic drain_all(input string tag);
    logic nopl;
    int n;
    while (exp_nopl.size() > 0) begin
      nopl = exp_nopl.pop_front();
      n = 0;
      while (o_head_req !== 1'b1 && n < 200) begin tick(); n++; end
      checks++;
      if (o_head_req !== 1'b1) begin failures++; $display("FAIL %s head_req_timeout got=%b exp=1", tag, o_head_req); end
      checks++;
      if (o_no_pload !== nopl) begin failures++; $display("FAIL %s no_pload got=%b exp=%b", tag, o_no_pload, nopl); end
      head_ack = 1'b1; tick(); head_ack = 1'b0;
      read_head_frame();
      if (!nopl) begin
        n = 0;
        while (o_pload_req !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (o_pload_req !== 1'b1) begin failures++; $display("FAIL %s pload_req_timeout got=%b exp=1", tag, o_pload_req); end
        pload_ack = 1'b1; tick(); pload_ack = 1'b0;
        read_pload_frame();
      end
      $display("%s frame drained no_pload=%0b", tag, nopl);
    end
    tick();
    checks++;
    if (o_head_empty !== 1'b1) begin failures++; $display("FAIL %s end_head_empty got=%b exp=1", tag, o_head_empty); end
    checks++;
    if (o_pload_empty !== 1'b1) begin failures++; $display("FAIL %s end_pload_empty got=%b exp=1", tag, o_pload_empty); end
    checks++;
    if (o_head_req !== 1'b0) begin failures++; $display("FAIL %s end_head_req got=%b exp=0", tag, o_head_req); end
    checks++;
    if (o_pload_req !== 1'b0) begin failures++; $display("FAIL %s end_pload_req got=%b exp=0", tag, o_pload_req); end
    checks++;
    if (exp_pt.size() != 0) begin failures++; $display("FAIL %s passthrough_missing got=%0d exp=0", tag, exp_pt.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; txen = 1'b0; txd = '0;
    head_ack = 1'b0; head_rd = 1'b0; pload_ack = 1'b0; pload_rd = 1'b0;
    repeat (3) tick();
    checks++; if (o_head_req !== 1'b0) begin failures++; $display("FAIL rst_head_req got=%b exp=0", o_head_req); end
    checks++; if (o_pload_req !== 1'b0) begin failures++; $display("FAIL rst_pload_req got=%b exp=0", o_pload_req); end
    checks++; if (o_no_pload !== 1'b0) begin failures++; $display("FAIL rst_no_pload got=%b exp=0", o_no_pload); end
    checks++; if (o_head_empty !== 1'b1) begin failures++; $display("FAIL rst_head_empty got=%b exp=1", o_head_empty); end
    checks++; if (o_pload_empty !== 1'b1) begin failures++; $display("FAIL rst_pload_empty got=%b exp=1", o_pload_empty); end
    checks++; if (o_head_full !== 1'b0) begin failures++; $display("FAIL rst_head_full got=%b exp=0", o_head_full); end
    checks++; if (o_pload_full !== 1'b0) begin failures++; $display("FAIL rst_pload_full got=%b exp=0", o_pload_full); end
    checks++; if (o_head_rdata !== 9'h000) begin failures++; $display("FAIL rst_head_rdata got=%h exp=000", o_head_rdata); end
    checks++; if (o_pload_rdata !== 9'h000) begin failures++; $display("FAIL rst_pload_rdata got=%h exp=000", o_pload_rdata); end
    checks++; if ({o_pload_txen, o_pload_txd} !== 9'h000) begin failures++; $display("FAIL rst_passthrough got=%h exp=000", {o_pload_txen, o_pload_txd}); end
`ifdef LZW_FWD_DROP_CNT_EN
    checks++; if (o_drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_drop_cnt got=%0d exp=0", o_drop_cnt); end
`endif
    rst_n = 1'b1;
    repeat (2) tick();
    $display("reset state checked");
  endtask

  task automatic test_long_frame();
    send_frame(60, 0, 1'b1);
    checks++; if (o_head_req !== 1'b0) begin failures++; $display("FAIL long_req_c1 got=%b exp=0", o_head_req); end
    tick();
    checks++; if ({o_head_req, o_pload_req} !== 2'b00) begin failures++; $display("FAIL long_req_c2 got=%b exp=00", {o_head_req, o_pload_req}); end
    tick();
    checks++; if (o_head_req !== 1'b1) begin failures++; $display("FAIL long_head_req_c3 got=%b exp=1", o_head_req); end
    checks++; if (o_pload_req !== 1'b1) begin failures++; $display("FAIL long_pload_req_c3 got=%b exp=1", o_pload_req); end
    drain_all("long");
  endtask

  task automatic test_short_frame();
    send_frame(10, 0, 1'b1);
    repeat (3) tick();
    checks++; if (o_head_req !== 1'b1) begin failures++; $display("FAIL short_head_req got=%b exp=1", o_head_req); end
    checks++; if (o_pload_req !== 1'b0) begin failures++; $display("FAIL short_pload_req got=%b exp=0", o_pload_req); end
    drain_all("short");
  endtask

  task automatic test_exact_head();
    send_frame(HEAD_LEN, 8'h40, 1'b1);
    repeat (3) tick();
    checks++; if (o_pload_empty !== 1'b1) begin failures++; $display("FAIL exact_pload_empty got=%b exp=1", o_pload_empty); end
    checks++; if (o_pload_req !== 1'b0) begin failures++; $display("FAIL exact_pload_req got=%b exp=0", o_pload_req); end
    drain_all("exact");
    send_frame(1, 8'h77, 1'b1);
    drain_all("one_byte");
  endtask

  task automatic test_idle_strobes();
    head_rd = 1'b1; pload_rd = 1'b1; head_ack = 1'b1; pload_ack = 1'b1;
    repeat (3) tick();
    head_rd = 1'b0; pload_rd = 1'b0; head_ack = 1'b0; pload_ack = 1'b0;
    tick();
    checks++; if ({o_head_empty, o_pload_empty} !== 2'b11) begin failures++; $display("FAIL idle_empty got=%b exp=11", {o_head_empty, o_pload_empty}); end
    checks++; if ({o_head_req, o_pload_req} !== 2'b00) begin failures++; $display("FAIL idle_req got=%b exp=00", {o_head_req, o_pload_req}); end
    send_frame(20, 8'hC0, 1'b1);
    drain_all("idle");
  endtask

  task automatic test_back_to_back();
    logic nopl;
    send_frame(20, 8'h00, 1'b1);
    send_frame(14, 8'h30, 1'b1);
    send_frame(30, 8'h50, 1'b1);
    repeat (3) tick();
    checks++; if ({o_head_req, o_pload_req} !== 2'b11) begin failures++; $display("FAIL b2b_req got=%b exp=11", {o_head_req, o_pload_req}); end
    send_frame(25, 8'h90, 1'b1);
    tick();
    // this cycle writes frame 4's eof word; acks land on the same edge
    nopl = exp_nopl.pop_front();
    checks++; if (o_no_pload !== nopl) begin failures++; $display("FAIL b2b_no_pload got=%b exp=%b", o_no_pload, nopl); end
    head_ack = 1'b1; pload_ack = 1'b1;
    tick();
    head_ack = 1'b0; pload_ack = 1'b0;
    checks++; if ({o_head_req, o_pload_req} !== 2'b11) begin failures++; $display("FAIL b2b_req_after_ack got=%b exp=11", {o_head_req, o_pload_req}); end
    read_head_frame();
    read_pload_frame();
    drain_all("b2b");
  endtask

  task automatic test_drop();
    send_frame(614, 8'h80, 1'b1);
    repeat (3) tick();
    send_frame(20, 8'h20, 1'b0);
    repeat (4) tick();
    checks++; if ({o_head_req, o_pload_req} !== 2'b11) begin failures++; $display("FAIL drop_req got=%b exp=11", {o_head_req, o_pload_req}); end
`ifdef LZW_FWD_DROP_CNT_EN
    checks++; if (o_drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", o_drop_cnt); end
`endif
    drain_all("drop_big");
    send_frame(60, 8'h10, 1'b1);
    drain_all("after_drop");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 40; i++) begin
      tick();
      txen = 1'b1;
      txd  = 8'(8'hA0 + i);
      rst_n = (i == 25) ? 1'b0 : 1'b1;
      if (i >= HEAD_LEN && i <= 23) exp_pt.push_back(8'(8'hA0 + i));
      if (i == 26) begin
        checks++; if ({o_head_empty, o_pload_empty} !== 2'b11) begin failures++; $display("FAIL midrst_empty got=%b exp=11", {o_head_empty, o_pload_empty}); end
        checks++; if ({o_head_req, o_pload_req} !== 2'b00) begin failures++; $display("FAIL midrst_req got=%b exp=00", {o_head_req, o_pload_req}); end
`ifdef LZW_FWD_DROP_CNT_EN
        checks++; if (o_drop_cnt !== 16'd0) begin failures++; $display("FAIL midrst_drop_cnt got=%0d exp=0", o_drop_cnt); end
`endif
      end
    end
    tick();
    txen = 1'b0;
    txd  = '0;
    repeat (4) tick();
    checks++; if ({o_head_empty, o_pload_empty} !== 2'b11) begin failures++; $display("FAIL midrst_tail_ignored got=%b exp=11", {o_head_empty, o_pload_empty}); end
    send_frame(30, 8'h05, 1'b1);
    drain_all("after_midrst");
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_long_frame();
    test_short_frame();
    test_exact_head();
    test_idle_strobes();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
